nco_sincos_tdm: RTL and testbench
=================================

Name: nco_sincos_tdm

Overview:
Time-multiplexed multi-channel NCO. It has per-channel phase accumulators, frequency words and phase offsets, and produces quadrature cos/sin outputs from a quarter-wave table with quadrant folding. Each clock with en=1 serves one channel, round-robin. It feeds the mixers and DDS paths that currently take a single-channel phase-to-sincos converter. It adds phase accumulation, multiple channels, runtime configuration, a synchronous clear and a valid/channel-tagged output.

Parameters:
NCH, 4, number of channels (>=1; need not be a power of 2)
NBP, 32, phase accumulator, frequency word and phase offset width
NBA, 10, quarter-wave table address bits (table depth 2^NBA)
NBD, 18, signed output width
CW (localparam), max(1, clog2(NCH)), channel index width

Ports:
c  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  serve current channel this cycle
clr  in  1  synchronous clear of accumulators, channel counter and pipeline
wr  in  1  config write strobe
wr_sel  in  1  0 = frequency word, 1 = phase offset
wr_ch  in  CW  channel written; values >= NCH are ignored
wr_data  in  NBP  value written
o_valid  out  1  output sample valid
o_ch  out  CW  channel of the output sample
o_cos  out  NBD  signed cosine
o_sin  out  NBD  signed sine

Behaviour:
- Reset (rst_n low, asynchronous): all accumulators, fw[], po[], channel counter and pipeline registers are 0. o_valid=0, o_ch=0, o_cos=0, o_sin=0.
- Channel counter ch: advances only when en=1; wraps from NCH-1 to 0. When en=0 it holds, and a bubble (valid=0) enters the pipeline.
- Service cycle (en=1, channel k):
  - phase = acc[k] + po[k], mod 2^NBP, using the pre-update acc.
  - acc[k] <= acc[k] + fw[k], mod 2^NBP.
  - The first service after reset or clr uses phase = po[k].
- Phase truncation: p = phase[NBP-1 -: NBA+2]. Quadrant q = p[NBA+1:NBA]; index i = p[NBA-1:0]; ~i is the bitwise complement.
- Table: T[j] = round((2^(NBD-1)-1) * cos((j+0.5)*pi/2^(NBA+1))), j = 0..2^NBA-1. It is half-LSB offset so folding with ~i is exact. All entries are positive.
- cos by quadrant: q0 +T[i]; q1 -T[~i]; q2 -T[i]; q3 +T[~i].
- sin by quadrant: q0 +T[~i]; q1 +T[i]; q2 -T[~i]; q3 -T[i].
- Negation is two's complement; overflow is impossible because |T| <= 2^(NBD-1)-1.
- Pipeline, fixed latency 4: a service in cycle n produces o_valid=1 in cycle n+4, with o_ch=k and the matching cos/sin.
  - S1: phase sum register.
  - S2: fold to address and sign.
  - S3: table read (synchronous, inferable as block RAM).
  - S4: sign apply and output register.
- On non-valid cycles o_cos, o_sin and o_ch hold their last values.
- Config writes:
  - wr=1 updates fw[wr_ch] or po[wr_ch] at the clock edge.
  - If the same channel is served in that cycle, the service uses the old value and the new value applies from the next service.
  - Writes never disturb acc[].
- clr=1:
  - Next edge: all acc[]=0, ch=0, all pipeline valid bits=0. In-flight samples are discarded and o_valid=0 on the following cycle.
  - fw[] and po[] are retained.
  - The service in the clr cycle is discarded.
  - clr and wr in the same cycle: both take effect.
- Back-to-back en=1 for any duration gives full throughput, one sample per clock.

Test Plan:
1. NCH=4, NBP=32, NBA=10, NBD=18, reset, then fw=po=0, en=1 continuous -> from cycle 4, o_valid=1, o_ch cycles 0,1,2,3, all samples o_cos=131071, o_sin=101.
2. po[0]=0x40000000 -> ch0 o_cos=-101, o_sin=131071. po[0]=0x80000000 -> o_cos=-131071, o_sin=-101. po[0]=0xC0000000 -> o_cos=101, o_sin=-131071.
3. fw[1]=0x40000000, po[1]=0 -> successive ch1 samples (cos,sin): (131071,101), (-101,131071), (-131071,-101), (101,-131071), then repeat. Checks accumulation wrap.
4. Toggle en in a random pattern -> ch advances only on en=1; o_valid is exactly en delayed 4 cycles; o_ch matches; accumulators advance once per service.
5. Write fw[2] in the same cycle ch2 is served -> that sample uses the old fw; the next ch2 sample reflects the new fw. Also write wr_ch=5 -> no state change.
6. Assert clr mid-stream, then separately drop rst_n mid-stream:
   - clr -> o_valid=0 on the next cycle; the first post-clr ch0 sample equals the po[0]-only value; fw/po retained.
   - rst_n low -> outputs 0 immediately (asynchronously); after release, fw=po=0 behaviour as in scenario 1.

Source files
------------

// File: rtl/nco_sincos_tdm.sv
// Round-robin multi-channel NCO: per-channel phase accumulators feed a folded
// quarter-wave cos table through a fixed four-stage pipeline.
module nco_sincos_tdm #(
  parameter int NCH = 4,
  parameter int NBP = 32,
  parameter int NBA = 10,
  parameter int NBD = 18,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  c,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  wr_sel,
  input  logic [CW-1:0]         wr_ch,
  input  logic [NBP-1:0]        wr_data,
  output logic                  o_valid,
  output logic [CW-1:0]         o_ch,
  output logic signed [NBD-1:0] o_cos,
  output logic signed [NBD-1:0] o_sin
);

  localparam int TD  = 1 << NBA;
  localparam int AMP = (1 << (NBD - 1)) - 1;

  // Half-LSB offset makes T[~i] the exact mirror of T[i] about the quarter point.
  function automatic logic [NBD-2:0] tbl_entry(input int j);
    real x;
    x = real'(AMP) * $cos((real'(j) + 0.5) * 3.14159265358979323846 / (real'(TD) * 2.0));
    return (NBD-1)'($rtoi(x + 0.5));
  endfunction

  logic [NBD-2:0] rom [TD];
  for (genvar j = 0; j < TD; j++) begin : g_rom
    assign rom[j] = tbl_entry(j);
  end

  logic [NBP-1:0] acc [NCH];
  logic [NBP-1:0] fw  [NCH];
  logic [NBP-1:0] po  [NCH];
  logic [CW-1:0]  ch;
  logic           wr_ok;

  if (NCH == (1 << CW)) begin : g_wr_full
    assign wr_ok = wr;
  end else begin : g_wr_range
    assign wr_ok = wr && (wr_ch < CW'(NCH));
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) acc[n] <= '0;
      ch <= '0;
    end else if (clr) begin
      for (int n = 0; n < NCH; n++) acc[n] <= '0;
      ch <= '0;
    end else if (en) begin
      acc[ch] <= acc[ch] + fw[ch];
      ch      <= (ch == CW'(NCH - 1)) ? '0 : ch + 1'b1;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) begin
        fw[n] <= '0;
        po[n] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) po[wr_ch] <= wr_data;
      else        fw[wr_ch] <= wr_data;
    end
  end

  logic [NBA+1:0] ph1;
  logic [CW-1:0]  ch1, ch2, ch3;
  logic           v1, v2, v3;
  logic [NBA-1:0] addr_c2, addr_s2;
  logic           neg_c2, neg_s2, neg_c3, neg_s3;
  logic [NBD-2:0] tc3, ts3;
  logic [1:0]     q1;
  logic [NBA-1:0] i1;
  logic [NBD-1:0] mag_c, mag_s;

  assign q1    = ph1[NBA+1:NBA];
  assign i1    = ph1[NBA-1:0];
  assign mag_c = {1'b0, tc3};
  assign mag_s = {1'b0, ts3};

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; ph1 <= '0; ch1 <= '0;
      v2 <= 1'b0; addr_c2 <= '0; addr_s2 <= '0; neg_c2 <= 1'b0; neg_s2 <= 1'b0; ch2 <= '0;
      v3 <= 1'b0; neg_c3 <= 1'b0; neg_s3 <= 1'b0; ch3 <= '0;
      o_valid <= 1'b0; o_ch <= '0; o_cos <= '0; o_sin <= '0;
    end else begin
      v1 <= en & ~clr;
      if (en) begin
        ph1 <= (NBA+2)'((acc[ch] + po[ch]) >> (NBP - NBA - 2));
        ch1 <= ch;
      end
      v2      <= v1 & ~clr;
      addr_c2 <= q1[0] ? ~i1 : i1;
      addr_s2 <= q1[0] ? i1 : ~i1;
      neg_c2  <= q1[1] ^ q1[0];
      neg_s2  <= q1[1];
      ch2     <= ch1;
      v3      <= v2 & ~clr;
      neg_c3  <= neg_c2;
      neg_s3  <= neg_s2;
      ch3     <= ch2;
      o_valid <= v3 & ~clr;
      if (v3 && !clr) begin
        o_ch  <= ch3;
        o_cos <= neg_c3 ? -mag_c : mag_c;
        o_sin <= neg_s3 ? -mag_s : mag_s;
      end
    end
  end

  // Table read kept free of reset so it maps onto a synchronous ROM/BRAM port.
  always_ff @(posedge c) begin
    tc3 <= rom[addr_c2];
    ts3 <= rom[addr_s2];
  end

endmodule

// File: tb/tb_nco_sincos_tdm.sv
// Directed bench for nco_sincos_tdm: a 4-channel and a 3-channel instance share
// stimulus; a behavioural acc/fw/po model with hand-computed octant values predicts outputs.
module tb_nco_sincos_tdm;

  typedef struct packed {
    logic               v;
    logic [1:0]         ch;
    logic signed [17:0] cs;
    logic signed [17:0] sn;
  } smp_t;

  logic c, rst_n, en, clr, wr, wr_sel;
  logic [1:0]  wr_ch;
  logic [31:0] wr_data;

  logic               v4, v3o;
  logic [1:0]         ch4, ch3o;
  logic signed [17:0] cos4, sin4, cos3o, sin3o;

  nco_sincos_tdm u4 (
    .c(c), .rst_n(rst_n), .en(en), .clr(clr), .wr(wr), .wr_sel(wr_sel),
    .wr_ch(wr_ch), .wr_data(wr_data),
    .o_valid(v4), .o_ch(ch4), .o_cos(cos4), .o_sin(sin4)
  );

  nco_sincos_tdm #(.NCH(3)) u3 (
    .c(c), .rst_n(rst_n), .en(en), .clr(clr), .wr(wr), .wr_sel(wr_sel),
    .wr_ch(wr_ch), .wr_data(wr_data),
    .o_valid(v3o), .o_ch(ch3o), .o_cos(cos3o), .o_sin(sin3o)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  logic [31:0] m_acc [2][4];
  logic [31:0] m_fw  [2][4];
  logic [31:0] m_po  [2][4];
  int          m_ch  [2];
  smp_t        m_st  [2][3];
  smp_t        m_out [2];

  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string tag;
  logic [31:0] po_list [5];
  logic [31:0] pat;

  // Phases used here are all multiples of pi/4; table values worked out by hand.
  function automatic smp_t oct_val(input logic [31:0] ph, input logic [1:0] k);
    smp_t r;
    r.v  = 1'b1;
    r.ch = k;
    case (ph[31:29])
      3'd0: begin r.cs =  18'sd131071; r.sn =  18'sd101;    end
      3'd1: begin r.cs =  18'sd92610;  r.sn =  18'sd92752;  end
      3'd2: begin r.cs = -18'sd101;    r.sn =  18'sd131071; end
      3'd3: begin r.cs = -18'sd92752;  r.sn =  18'sd92610;  end
      3'd4: begin r.cs = -18'sd131071; r.sn = -18'sd101;    end
      3'd5: begin r.cs = -18'sd92610;  r.sn = -18'sd92752;  end
      3'd6: begin r.cs =  18'sd101;    r.sn = -18'sd131071; end
      default: begin r.cs = 18'sd92752; r.sn = -18'sd92610; end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[d][k] = '0;
        m_fw[d][k]  = '0;
        m_po[d][k]  = '0;
      end
      for (int s = 0; s < 3; s++) m_st[d][s] = '0;
      m_ch[d]  = 0;
      m_out[d] = '0;
    end
  endtask

  task automatic model_edge(input logic e, cl, w, s, input logic [1:0] wc, input logic [31:0] wd);
    for (int d = 0; d < 2; d++) begin
      int nch;
      int k;
      logic [31:0] ph;
      nch = (d == 0) ? 4 : 3;
      if (cl) m_out[d].v = 1'b0;
      else if (m_st[d][2].v) m_out[d] = m_st[d][2];
      else m_out[d].v = 1'b0;
      if (cl) begin
        for (int st = 0; st < 3; st++) m_st[d][st] = '0;
        for (int n = 0; n < 4; n++) m_acc[d][n] = '0;
        m_ch[d] = 0;
      end else begin
        m_st[d][2] = m_st[d][1];
        m_st[d][1] = m_st[d][0];
        if (e) begin
          k  = m_ch[d];
          ph = m_acc[d][k] + m_po[d][k];
          m_st[d][0]  = oct_val(ph, 2'(k));
          m_acc[d][k] = m_acc[d][k] + m_fw[d][k];
          m_ch[d]     = (k == nch - 1) ? 0 : k + 1;
        end else begin
          m_st[d][0] = '0;
        end
      end
      if (w && int'(wc) < nch) begin
        if (s) m_po[d][wc] = wd;
        else   m_fw[d][wc] = wd;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic v, input logic [1:0] ch,
                           input logic signed [17:0] cs, input logic signed [17:0] sn);
    n_chk++;
    assert (v === m_out[d].v && ch === m_out[d].ch && cs === m_out[d].cs && sn === m_out[d].sn)
      n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: got v=%0d ch=%0d cos=%0d sin=%0d, expected v=%0d ch=%0d cos=%0d sin=%0d",
             tag, d, v, ch, cs, sn, m_out[d].v, m_out[d].ch, m_out[d].cs, m_out[d].sn);
    end
  endtask

  task automatic check_all();
    check_dut(0, v4, ch4, cos4, sin4);
    check_dut(1, v3o, ch3o, cos3o, sin3o);
  endtask

  task automatic cyc(input logic e, cl, w, s, input logic [1:0] wc, input logic [31:0] wd);
    en = e; clr = cl; wr = w; wr_sel = s; wr_ch = wc; wr_data = wd;
    model_edge(e, cl, w, s, wc, wd);
    @(negedge c);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic run();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; clr = 1'b0; wr = 1'b0; wr_sel = 1'b0;
    wr_ch = 2'd0; wr_data = 32'd0;
    po_list[0] = 32'h4000_0000;
    po_list[1] = 32'h8000_0000;
    po_list[2] = 32'hC000_0000;
    po_list[3] = 32'h2000_0000;
    po_list[4] = 32'h6000_0000;
    pat = 32'hB2E6_9C75;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge c);
    tag = "reset";
    check_all();
    rst_n = 1'b1;

    tag = "zero_cfg";
    repeat (12) run();
    repeat (4) idle();

    tag = "po_quadrant";
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, po_list[i]);
      run();
      repeat (5) idle();
    end

    tag = "fw_wrap";
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h4000_0000);
    repeat (22) run();
    repeat (4) idle();

    tag = "en_pattern";
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h4000_0000);
    for (int i = 0; i < 32; i++) cyc(pat[i], 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (4) idle();

    tag = "wr_collide";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    run();
    run();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h4000_0000);
    run();
    run();
    run();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h8000_0000);
    repeat (10) run();
    tag = "wr_range";
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 32'h2000_0000);
    repeat (12) run();
    repeat (4) idle();

    tag = "clr_stream";
    repeat (6) run();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (10) run();
    repeat (4) idle();

    tag = "async_rst";
    repeat (5) run();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge c);
    check_all();
    rst_n = 1'b1;
    tag = "post_rst";
    repeat (12) run();
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
